// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave byte controllers.
//   - wr_state_t : byte-write sequencer states
//   - DATA_WIDTH_DEF : default bits per transfer
//   - ACK_LVL / NACK_LVL : SDA level the master drives in the ACK slot
package i2c_pkg;

    localparam int DATA_WIDTH_DEF = 8;

    localparam logic ACK_LVL  = 1'b0;
    localparam logic NACK_LVL = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_GAP      = 3'd2,
        ST_ACK_RISE = 3'd3,
        ST_ACK_FALL = 3'd4
    } wr_state_t;

endpackage

// File: rtl/i2c_scl_edge_detect.sv
// SCL edge detector shared by the slave byte controllers.
// Ports:
//   clk, rst  : clock, asynchronous active-high reset
//   scl_i     : synchronised SCL
//   scl_rise  : combinational, high the cycle SCL is first seen high
//   scl_fall  : combinational, high the cycle SCL is first seen low
// scl_last resets high (bus idle level) so a bus already idling high does
// not produce a spurious rise right after reset.
module i2c_scl_edge_detect (
    input  logic clk,
    input  logic rst,
    input  logic scl_i,
    output logic scl_rise,
    output logic scl_fall
);

    logic scl_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) scl_last <= 1'b1;
        else     scl_last <= scl_i;
    end

    assign scl_rise = ~scl_last &  scl_i;
    assign scl_fall =  scl_last & ~scl_i;

endmodule

// File: rtl/i2c_slave_write_byte_ctrl.sv
// Slave-side transmit sequencer: shifts one byte MSB first through the
// bit-write datapath, then releases SDA for the master's ACK/NACK slot.
// Ports:
//   clk, rst            : clock, asynchronous active-high reset
//   byte_write_en       : request, held for the whole transfer; low aborts
//   byte_write_i        : byte to send, captured when leaving IDLE
//   byte_write_finish   : one-cycle pulse after the ACK slot's SCL fall
//   ack_o               : 1 = master ACKed; held until the next capture
//   bit_write_en        : enable to the bit-write module
//   bit_write_i         : bit currently presented to the bit-write module
//   bit_write_finish    : bit slot complete pulse from the bit-write module
//   scl_i, sda_i        : synchronised bus lines
//   sda_release         : 1 = top level must tri-state SDA
module i2c_slave_write_byte_ctrl
    import i2c_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  byte_write_en,
    input  logic [DATA_WIDTH-1:0] byte_write_i,
    output logic                  byte_write_finish,
    output logic                  ack_o,
    output logic                  bit_write_en,
    output logic                  bit_write_i,
    input  logic                  bit_write_finish,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_release
);

    localparam int CW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    wr_state_t             state;
    logic [CW-1:0]         cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  scl_rise;
    logic                  scl_fall;

    i2c_scl_edge_detect u_scl_edge (
        .clk      (clk),
        .rst      (rst),
        .scl_i    (scl_i),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall)
    );

    // The next bit is already in the MSB during GAP; gating with the enable
    // keeps the line at 0 whenever the bit module is not being driven.
    assign bit_write_i = bit_write_en & shift_reg[DATA_WIDTH-1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= ST_IDLE;
            cnt               <= '0;
            shift_reg         <= '0;
            byte_write_finish <= 1'b0;
            ack_o             <= 1'b0;
            bit_write_en      <= 1'b0;
            sda_release       <= 1'b1;
        end else begin
            byte_write_finish <= 1'b0;
            // Abort takes priority over any event seen in the same cycle.
            if (state != ST_IDLE && !byte_write_en) begin
                state        <= ST_IDLE;
                bit_write_en <= 1'b0;
                sda_release  <= 1'b1;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (byte_write_en) begin
                            shift_reg    <= byte_write_i;
                            cnt          <= CW'(DATA_WIDTH - 1);
                            ack_o        <= 1'b0;
                            bit_write_en <= 1'b1;
                            sda_release  <= 1'b0;
                            state        <= ST_SEND;
                        end
                    end
                    ST_SEND: begin
                        if (bit_write_finish) begin
                            bit_write_en <= 1'b0;
                            if (cnt == '0) begin
                                sda_release <= 1'b1;
                                state       <= ST_ACK_RISE;
                            end else begin
                                shift_reg <= shift_reg << 1;
                                cnt       <= cnt - 1'b1;
                                state     <= ST_GAP;
                            end
                        end
                    end
                    // One low cycle of bit_write_en lets the bit module re-arm.
                    ST_GAP: begin
                        bit_write_en <= 1'b1;
                        state        <= ST_SEND;
                    end
                    ST_ACK_RISE: begin
                        if (scl_rise) begin
                            ack_o <= (sda_i == ACK_LVL);
                            state <= ST_ACK_FALL;
                        end
                    end
                    ST_ACK_FALL: begin
                        if (scl_fall) begin
                            byte_write_finish <= 1'b1;
                            state             <= ST_IDLE;
                        end
                    end
                    default: begin
                        bit_write_en <= 1'b0;
                        sda_release  <= 1'b1;
                        state        <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_slave_write_byte_ctrl.sv
// Bench for i2c_slave_write_byte_ctrl. A behavioural bit module drives SCL,
// samples each presented bit and pulses bit_write_finish; it also plays the
// master in the ACK slot. Expected bits/acks are queued when a byte is driven
// and popped as the DUT produces them.
module tb_i2c_slave_write_byte_ctrl;
    import i2c_pkg::*;

    logic       clk;
    logic       rst;
    logic       byte_write_en;
    logic [7:0] byte_write_i;
    logic       byte_write_finish;
    logic       ack_o;
    logic       bit_write_en;
    logic       bit_write_i;
    logic       bit_write_finish;
    logic       scl_i;
    logic       sda_i;
    logic       sda_release;

    logic       bwf_model;
    logic       bwf_stray;
    assign bit_write_finish = bwf_model | bwf_stray;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   fin_cnt = 0;
    int   nbits;
    logic ack_phase;
    logic prev_fin = 1'b0;

    logic exp_bits[$];
    logic exp_ack[$];
    logic drv_ack[$];

    i2c_slave_write_byte_ctrl #(.DATA_WIDTH(8)) dut (
        .clk               (clk),
        .rst               (rst),
        .byte_write_en     (byte_write_en),
        .byte_write_i      (byte_write_i),
        .byte_write_finish (byte_write_finish),
        .ack_o             (ack_o),
        .bit_write_en      (bit_write_en),
        .bit_write_i       (bit_write_i),
        .bit_write_finish  (bit_write_finish),
        .scl_i             (scl_i),
        .sda_i             (sda_i),
        .sda_release       (sda_release)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one byte and wait for its finish pulse. last=1 drops the request
    // in the finish cycle; otherwise the caller queues the next byte at once.
    task automatic xfer(input logic [7:0] d, input logic lvl, input bit last);
        logic tmo;
        for (int i = 7; i >= 0; i--) exp_bits.push_back(d[i]);
        exp_ack.push_back(lvl == ACK_LVL);
        drv_ack.push_back(lvl);
        byte_write_i  = d;
        byte_write_en = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (byte_write_finish) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("xfer_tmo", {31'd0, tmo}, 0);
        if (last || tmo) byte_write_en = 1'b0;
    endtask

    // Bit-module / master model.
    initial begin
        scl_i = 1'b1; sda_i = 1'b1; bwf_model = 1'b0; nbits = 0; ack_phase = 1'b0;
        forever begin
            @(negedge clk);
            if (!byte_write_en || rst) nbits = 0;
            else if (bit_write_en) begin
                scl_i = 1'b0;
                sda_i = bit_write_i;
                repeat (2) @(negedge clk);
                scl_i = 1'b1;
                if (exp_bits.size() == 0) chk("extra_bit", {31'd0, bit_write_en}, 0);
                else chk("bit", {31'd0, bit_write_i}, {31'd0, exp_bits.pop_front()});
                repeat (2) @(negedge clk);
                scl_i = 1'b0;
                bwf_model = 1'b1;
                @(negedge clk);
                bwf_model = 1'b0;
                nbits++;
                if (nbits < 8) begin
                    if (byte_write_en) chk("gap_lo", {31'd0, bit_write_en}, 0);
                    @(negedge clk);
                    if (byte_write_en) chk("gap_hi", {31'd0, bit_write_en}, 1);
                end else begin
                    ack_phase = 1'b1;
                    if (drv_ack.size() != 0) sda_i = drv_ack.pop_front();
                    else sda_i = NACK_LVL;
                    @(negedge clk);
                    chk("ack_rel", {31'd0, sda_release}, 1);
                    scl_i = 1'b1;
                    repeat (2) begin
                        @(negedge clk);
                        chk("ack_rel", {31'd0, sda_release}, 1);
                    end
                    scl_i = 1'b0;
                    @(negedge clk);
                    chk("ack_rel", {31'd0, sda_release}, 1);
                    sda_i = 1'b1;
                    ack_phase = 1'b0;
                    nbits = 0;
                end
            end
        end
    end

    // Finish monitor: single-cycle pulse, ack against the scoreboard.
    initial forever begin
        @(negedge clk);
        if (byte_write_finish) begin
            fin_cnt++;
            chk("fin_1cyc", {31'd0, prev_fin}, 0);
            if (exp_ack.size() == 0) chk("unexp_fin", {31'd0, byte_write_finish}, 0);
            else chk("ack", {31'd0, ack_o}, {31'd0, exp_ack.pop_front()});
        end
        prev_fin = byte_write_finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int   f0;
        logic tmo;
        logic [7:0] b2b [4];
        b2b[0] = 8'h13; b2b[1] = 8'h57; b2b[2] = 8'h9B; b2b[3] = 8'hDF;

        rst = 1'b1; byte_write_en = 1'b0; byte_write_i = 8'h00; bwf_stray = 1'b0;
        idle(3);
        chk("rst_fin", {31'd0, byte_write_finish}, 0);
        chk("rst_ack", {31'd0, ack_o}, 0);
        chk("rst_bwe", {31'd0, bit_write_en}, 0);
        chk("rst_bwi", {31'd0, bit_write_i}, 0);
        chk("rst_rel", {31'd0, sda_release}, 1);
        rst = 1'b0;
        idle(2);

        // ACKed byte
        f0 = fin_cnt;
        xfer(8'hA5, ACK_LVL, 1'b1);
        idle(5);
        chk("t1_fins", fin_cnt - f0, 1);
        chk("t1_ack_hold", {31'd0, ack_o}, 1);

        // NACKed byte
        f0 = fin_cnt;
        xfer(8'h3C, NACK_LVL, 1'b1);
        idle(5);
        chk("t2_fins", fin_cnt - f0, 1);
        chk("t2_ack_hold", {31'd0, ack_o}, 0);

        // back-to-back with the request held
        f0 = fin_cnt;
        for (int i = 0; i < 4; i++) xfer(b2b[i], (i == 2) ? NACK_LVL : ACK_LVL, i == 3);
        idle(5);
        chk("t3_fins", fin_cnt - f0, 4);

        // abort coincident with the 3rd bit finish
        for (int i = 7; i >= 0; i--) exp_bits.push_back(1'b1);
        byte_write_i = 8'hFF; byte_write_en = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (bit_write_finish && nbits == 2) begin
                tmo = 1'b0;
                break;
            end
        end
        byte_write_en = 1'b0;
        exp_bits.delete();
        chk("t4_tmo", {31'd0, tmo}, 0);
        f0 = fin_cnt;
        @(posedge clk); #1;
        chk("t4_bwe", {31'd0, bit_write_en}, 0);
        chk("t4_rel", {31'd0, sda_release}, 1);
        idle(20);
        chk("t4_nofin", fin_cnt - f0, 0);
        chk("t4_ack", {31'd0, ack_o}, 0);
        f0 = fin_cnt;
        xfer(8'h81, ACK_LVL, 1'b1);
        idle(3);
        chk("t4_after_fins", fin_cnt - f0, 1);

        // reset during ACK_FALL
        for (int i = 7; i >= 0; i--) exp_bits.push_back(1'b0 ^ ((8'h5A >> i) & 1));
        drv_ack.push_back(ACK_LVL);
        byte_write_i = 8'h5A; byte_write_en = 1'b1;
        tmo = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk); #1;
            if (ack_phase && scl_i) begin
                tmo = 1'b0;
                break;
            end
        end
        chk("t5_tmo", {31'd0, tmo}, 0);
        @(posedge clk); #2;
        chk("t5_ack_pre", {31'd0, ack_o}, 1);
        f0 = fin_cnt;
        rst = 1'b1;
        #1;
        chk("t5_fin", {31'd0, byte_write_finish}, 0);
        chk("t5_ack", {31'd0, ack_o}, 0);
        chk("t5_bwe", {31'd0, bit_write_en}, 0);
        chk("t5_bwi", {31'd0, bit_write_i}, 0);
        chk("t5_rel", {31'd0, sda_release}, 1);
        byte_write_en = 1'b0;
        idle(4);
        rst = 1'b0;
        idle(10);
        chk("t5_nofin", fin_cnt - f0, 0);
        f0 = fin_cnt;
        xfer(8'h00, ACK_LVL, 1'b1);
        idle(3);
        chk("t5_after_fins", fin_cnt - f0, 1);
        chk("t5_after_ack", {31'd0, ack_o}, 1);

        // stray bit_write_finish while idle
        f0 = fin_cnt;
        bwf_stray = 1'b1;
        @(negedge clk);
        bwf_stray = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t6_bwe", {31'd0, bit_write_en}, 0);
            chk("t6_rel", {31'd0, sda_release}, 1);
        end
        chk("t6_nofin", fin_cnt - f0, 0);

        chk("bits_left", exp_bits.size(), 0);
        chk("acks_left", exp_ack.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
